// File: rtl/dds_nco_if.sv
// ICB register bus between a bus master and the dds_nco peripheral.
// Acks and read data are produced combinationally by the slave.
interface dds_nco_if;
  logic        icb_wr;
  logic [7:0]  icb_wadr;
  logic [31:0] icb_wdat;
  logic        icb_wack;
  logic        icb_rd;
  logic [7:0]  icb_radr;
  logic [31:0] icb_rdat;
  logic        icb_rack;

  modport master (
    output icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr,
    input  icb_wack, icb_rdat, icb_rack
  );

  modport slave (
    input  icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr,
    output icb_wack, icb_rdat, icb_rack
  );
endinterface

// File: rtl/dds_nco.sv
// dds_nco: register-configured NCO producing quadrature 16-bit sine/cosine.
// A 32-bit phase accumulator advances by the frequency word while enabled;
// its top 10 bits index a quarter-wave sine ROM folded to a full period.
module dds_nco (
  input  logic               clk,
  input  logic               rst_,
  dds_nco_if.slave           bus,
  output logic signed [15:0] o_sin_dout,
  output logic signed [15:0] o_cos_dout
);

  // pi/2 in unsigned Q60 (hex expansion of pi shifted right by one)
  localparam logic [127:0] HALF_PI_Q60 = 128'h1921FB54442D1846;
  localparam int           QW_ENTRIES  = 257;

  // Builds round(32767*sin(pi/2*k/256)) for k = 0..256 at elaboration time
  // with a Q60 Taylor series; integer-only so every tool can fold it.
  function automatic logic [QW_ENTRIES*16-1:0] build_qrom();
    logic [QW_ENTRIES*16-1:0] v;
    logic [127:0]             x;
    logic [127:0]             x2;
    logic [127:0]             term;
    logic [127:0]             acc;
    v = '0;
    for (int k = 0; k < QW_ENTRIES; k++) begin
      x    = (HALF_PI_Q60 * 128'(k)) >> 8;
      x2   = (x * x) >> 60;
      term = x;
      acc  = x;
      for (int n = 1; n <= 12; n++) begin
        term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
        if ((n % 2) == 1)
          acc = acc - term;
        else
          acc = acc + term;
      end
      v[k*16 +: 16] = 16'((acc * 128'd32767 + (128'd1 << 59)) >> 60);
    end
    return v;
  endfunction

  localparam logic [QW_ENTRIES*16-1:0] QROM = build_qrom();

  // Full-period sine from the quarter table: quadrant bit 8 mirrors the
  // index, quadrant bit 9 negates the magnitude.
  function automatic logic [15:0] wave(input logic [9:0] a);
    logic [8:0]  idx;
    logic [15:0] mag;
    idx = a[8] ? (9'd256 - {1'b0, a[7:0]}) : {1'b0, a[7:0]};
    mag = QROM[{idx, 4'b0000} +: 16];
    return a[9] ? (16'd0 - mag) : mag;
  endfunction

  logic [255:0] w_wr_sel;
  logic [255:0] w_rd_sel;
  logic [31:0]  r_fcw;
  logic         r_dds_en;
  logic [31:0]  r_sum_fcw;
  logic [9:0]   w_addr;
  logic [31:0]  w_rdat;

  // One-hot address decode of both strobes
  assign w_wr_sel = 256'(bus.icb_wr) << bus.icb_wadr;
  assign w_rd_sel = 256'(bus.icb_rd) << bus.icb_radr;

  // Every address decodes to exactly one bit, so the OR of the bus equals
  // the strobe itself: unmapped addresses are acknowledged too.
  assign bus.icb_wack = |w_wr_sel;
  assign bus.icb_rack = |w_rd_sel;

  // Configuration registers: CON0 frequency word, CON1 bit 0 enable
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_fcw    <= '0;
      r_dds_en <= 1'b0;
    end else begin
      if (w_wr_sel[0]) r_fcw    <= bus.icb_wdat;
      if (w_wr_sel[1]) r_dds_en <= bus.icb_wdat[0];
    end
  end

  // Read mux of current register values; unmapped addresses read zero
  always_comb begin
    w_rdat = '0;
    if (w_rd_sel[0]) w_rdat = r_fcw;
    if (w_rd_sel[1]) w_rdat = {31'd0, r_dds_en};
  end

  assign bus.icb_rdat = w_rdat;

  // Phase accumulator: natural 32-bit wrap, holds (not cleared) when disabled
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      r_sum_fcw <= '0;
    else if (r_dds_en)
      r_sum_fcw <= r_sum_fcw + r_fcw;
  end

  assign w_addr     = r_sum_fcw[31:22];
  assign o_sin_dout = wave(w_addr);
  assign o_cos_dout = wave(w_addr + 10'd256);

endmodule

// File: tb/tb_dds_nco.sv
// Self-checking bench for dds_nco: directed register/sweep/hold scenarios
// followed by randomized bus traffic, all against a behavioural model.
module tb_dds_nco;

  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_;
  logic signed [15:0] sin_dout;
  logic signed [15:0] cos_dout;

  always #5 clk = ~clk;

  dds_nco_if bus ();

  dds_nco u_dut (
    .clk        (clk),
    .rst_       (rst_),
    .bus        (bus),
    .o_sin_dout (sin_dout),
    .o_cos_dout (cos_dout)
  );

  // Behavioural model state
  bit [31:0] m_fcw;
  bit        m_en;
  bit [31:0] m_phase;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // round(32767 * sin/cos(2*pi*a/1024)), half away from zero
  function automatic logic [15:0] ref_wave(input bit [9:0] a, input bit is_cos);
    real th;
    real v;
    int  r;
    th = 2.0 * PI * real'(a) / 1024.0;
    v  = 32767.0 * (is_cos ? $cos(th) : $sin(th));
    if (v >= 0.0) r = $rtoi($floor(v + 0.5));
    else          r = -$rtoi($floor(-v + 0.5));
    return 16'(r);
  endfunction

  function automatic logic [31:0] model_read(input bit [7:0] a);
    if (a == 8'h00) return m_fcw;
    if (a == 8'h01) return {31'd0, m_en};
    return 32'd0;
  endfunction

  function automatic bit [9:0] m_addr();
    return m_phase[31:22];
  endfunction

  // One bus cycle: drive at negedge, check combinational bus outputs,
  // advance the model at the rising edge, then check the samples.
  task automatic tick(input bit wr, input bit [7:0] wadr, input bit [31:0] wdat,
                      input bit rd, input bit [7:0] radr);
    bus.icb_wr   = wr;
    bus.icb_wadr = wadr;
    bus.icb_wdat = wdat;
    bus.icb_rd   = rd;
    bus.icb_radr = radr;
    #1;
    check("wack", {31'd0, bus.icb_wack}, {31'd0, wr});
    check("rack", {31'd0, bus.icb_rack}, {31'd0, rd});
    if (rd) check("rdat", bus.icb_rdat, model_read(radr));
    @(posedge clk);
    if (m_en) m_phase = m_phase + m_fcw;
    if (wr && wadr == 8'h00) m_fcw = wdat;
    if (wr && wadr == 8'h01) m_en  = wdat[0];
    @(negedge clk);
    bus.icb_wr = 1'b0;
    bus.icb_rd = 1'b0;
    check("sin", {16'd0, sin_dout}, {16'd0, ref_wave(m_addr(), 1'b0)});
    check("cos", {16'd0, cos_dout}, {16'd0, ref_wave(m_addr(), 1'b1)});
  endtask

  task automatic idle();
    tick(1'b0, 8'h00, 32'd0, 1'b0, 8'h00);
  endtask

  task automatic wr_reg(input bit [7:0] a, input bit [31:0] d);
    tick(1'b1, a, d, 1'b0, 8'h00);
  endtask

  task automatic rd_reg(input bit [7:0] a);
    tick(1'b0, 8'h00, 32'd0, 1'b1, a);
  endtask

  // Fixed landmark values of the step-by-one sweep
  task automatic key_points();
    if (m_addr() == 10'd256) begin
      check("sin@256", {16'd0, sin_dout}, 32'h0000_7FFF);
      check("cos@256", {16'd0, cos_dout}, 32'h0000_0000);
    end
    if (m_addr() == 10'd512) begin
      check("sin@512", {16'd0, sin_dout}, 32'h0000_0000);
      check("cos@512", {16'd0, cos_dout}, 32'h0000_8001);
    end
    if (m_addr() == 10'd768)
      check("sin@768", {16'd0, sin_dout}, 32'h0000_8001);
  endtask

  task automatic model_reset();
    m_fcw   = '0;
    m_en    = 1'b0;
    m_phase = '0;
  endtask

  initial begin
    bus.icb_wr   = 1'b0;
    bus.icb_wadr = '0;
    bus.icb_wdat = '0;
    bus.icb_rd   = 1'b0;
    bus.icb_radr = '0;
    rst_ = 1'b0;
    model_reset();

    // Reset state
    #3;
    check("rst_sin", {16'd0, sin_dout}, 32'h0000_0000);
    check("rst_cos", {16'd0, cos_dout}, 32'h0000_7FFF);
    bus.icb_rd = 1'b1; bus.icb_radr = 8'h00; #1;
    check("rst_rd0", bus.icb_rdat, 32'd0);
    check("rst_rack", {31'd0, bus.icb_rack}, 32'd1);
    bus.icb_radr = 8'h01; #1;
    check("rst_rd1", bus.icb_rdat, 32'd0);
    bus.icb_rd = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    idle();

    // Register access; same-cycle read of CON0 returns the old value
    tick(1'b1, 8'h00, 32'h1234_5678, 1'b1, 8'h00);
    wr_reg(8'h01, 32'hFFFF_FFFF);
    bus.icb_rd = 1'b1; bus.icb_radr = 8'h00; #1;
    check("con0_rd", bus.icb_rdat, 32'h1234_5678);
    bus.icb_radr = 8'h01; #1;
    check("con1_rd", bus.icb_rdat, 32'h0000_0001);
    bus.icb_radr = 8'h05; #1;
    check("unmapped_rd", bus.icb_rdat, 32'h0000_0000);
    bus.icb_rd = 1'b0;
    @(negedge clk);
    m_phase = m_phase + m_fcw;
    rd_reg(8'h00);
    wr_reg(8'h07, 32'hDEAD_BEEF);
    rd_reg(8'h07);
    tick(1'b1, 8'h01, 32'd0, 1'b1, 8'h01);
    rd_reg(8'h01);
    for (int i = 0; i < 5; i++) idle();

    // Asynchronous reset in mid-run
    wr_reg(8'h01, 32'd1);
    for (int i = 0; i < 20; i++) idle();
    #2;
    rst_ = 1'b0;
    model_reset();
    #1;
    check("mid_rst_sin", {16'd0, sin_dout}, 32'h0000_0000);
    check("mid_rst_cos", {16'd0, cos_dout}, 32'h0000_7FFF);
    bus.icb_rd = 1'b1; bus.icb_radr = 8'h00; #1;
    check("mid_rst_rd0", bus.icb_rdat, 32'd0);
    check("mid_rst_rack", {31'd0, bus.icb_rack}, 32'd1);
    bus.icb_radr = 8'h01; #1;
    check("mid_rst_rd1", bus.icb_rdat, 32'd0);
    bus.icb_rd = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    idle();

    // Step-by-one sweep with one-cycle enable latency
    wr_reg(8'h00, 32'h0040_0000);
    wr_reg(8'h01, 32'd1);
    check("en_latency_sin", {16'd0, sin_dout}, 32'h0000_0000);
    idle();
    check("first_step_sin", {16'd0, sin_dout}, {16'd0, ref_wave(10'd1, 1'b0)});
    while (m_addr() != 10'd99) begin
      idle();
      key_points();
    end
    // Disable lands on the edge that reaches 100
    wr_reg(8'h01, 32'd0);
    for (int i = 0; i < 50; i++) begin
      idle();
      check("hold_sin", {16'd0, sin_dout}, {16'd0, ref_wave(10'd100, 1'b0)});
    end
    wr_reg(8'h01, 32'd1);
    check("resume_latency", {16'd0, sin_dout}, {16'd0, ref_wave(10'd100, 1'b0)});
    idle();
    check("resume_step", {16'd0, sin_dout}, {16'd0, ref_wave(10'd101, 1'b0)});
    for (int i = 0; i < 1024 - 101; i++) begin
      idle();
      key_points();
    end
    check("wrap_sin", {16'd0, sin_dout}, 32'h0000_0000);
    check("wrap_cos", {16'd0, cos_dout}, 32'h0000_7FFF);

    // Frequency change while running
    for (int i = 0; i < 10; i++) idle();
    wr_reg(8'h00, 32'h0080_0000);
    check("fcw_old_word", {16'd0, sin_dout}, {16'd0, ref_wave(10'd11, 1'b0)});
    idle();
    check("fcw_new_word1", {16'd0, sin_dout}, {16'd0, ref_wave(10'd13, 1'b0)});
    idle();
    check("fcw_new_word2", {16'd0, sin_dout}, {16'd0, ref_wave(10'd15, 1'b0)});

    // Randomized bus traffic
    for (int i = 0; i < 3000; i++) begin
      bit        wr;
      bit        rd;
      bit [7:0]  wadr;
      bit [7:0]  radr;
      bit [31:0] wdat;
      int        sel;
      wr   = ($urandom_range(0, 7) == 0);
      rd   = ($urandom_range(0, 1) == 0);
      sel  = $urandom_range(0, 3);
      wadr = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h01 : 8'($urandom_range(0, 255));
      sel  = $urandom_range(0, 3);
      radr = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h01 : 8'($urandom_range(0, 255));
      wdat = $urandom();
      tick(wr, wadr, wdat, rd, radr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
